// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and data bundle for the sequential binary-to-BCD converter.
// The master drives the request and operand; the slave returns status and result.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  start_i;
    logic [BIN_W-1:0]      bin_i;
    logic                  busy_o;
    logic                  done_o;
    logic [DIGITS*4-1:0]   bcd_o;
    logic                  ovf_o;

    modport master (
        output start_i,
        output bin_i,
        input  busy_o,
        input  done_o,
        input  bcd_o,
        input  ovf_o
    );

    modport slave (
        input  start_i,
        input  bin_i,
        output busy_o,
        output done_o,
        output bcd_o,
        output ovf_o
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter using shift-add-3 (double dabble).
// One operand bit is consumed per clock, so the datapath is a single column of
// add-3 correctors regardless of BIN_W. Digits that fall off the top are
// folded into a sticky overflow flag; the remaining digits are value mod 10^DIGITS.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    bin_to_bcd_seq_if.slave   bus
);
    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t              r_state;
    logic [BIN_W-1:0]    r_bin;
    logic [BCD_W-1:0]    r_scratch;
    logic [CNT_W-1:0]    r_count;
    logic                r_ovf_sticky;
    logic                r_busy;
    logic                r_done;
    logic [BCD_W-1:0]    r_bcd;
    logic                r_ovf;

    logic [BCD_W-1:0]    w_adj;
    logic [BCD_W-1:0]    w_shifted;
    logic                w_carry;

    // Add-3 correction on every scratch digit in parallel, ahead of the shift.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign w_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] > 4'd4)
                                      ? r_scratch[gi*4 +: 4] + 4'd3
                                      : r_scratch[gi*4 +: 4];
        end
    endgenerate

    // Next scratch value: corrected digits shifted left with the operand MSB entering digit 0.
    // The bit pushed out of the top digit represents a lost multiple of 10^DIGITS.
    assign w_shifted = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
    assign w_carry   = w_adj[BCD_W-1];

    // Control FSM and datapath: load on start, shift BIN_W times, publish result with a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bin        <= '0;
            r_scratch    <= '0;
            r_count      <= '0;
            r_ovf_sticky <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bcd        <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        r_bin        <= bus.bin_i;
                        r_scratch    <= '0;
                        r_ovf_sticky <= 1'b0;
                        r_count      <= CNT_W'(BIN_W);
                        r_busy       <= 1'b1;
                        r_state      <= CONV;
                    end
                end
                CONV: begin
                    r_scratch    <= w_shifted;
                    r_bin        <= {r_bin[BIN_W-2:0], 1'b0};
                    r_ovf_sticky <= r_ovf_sticky | w_carry;
                    r_count      <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        r_bcd   <= w_shifted;
                        r_ovf   <= r_ovf_sticky | w_carry;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy_o = r_busy;
    assign bus.done_o = r_done;
    assign bus.bcd_o  = r_bcd;
    assign bus.ovf_o  = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq: a 7-bit/2-digit instance and a
// default 16-bit/5-digit instance share clock and reset.
module tb_bin_to_bcd_seq;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    bin_to_bcd_seq_if #(.BIN_W(7),  .DIGITS(2)) s_if ();
    bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) d_if ();

    bin_to_bcd_seq #(.BIN_W(7), .DIGITS(2)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if.slave)
    );

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dflt (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (d_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Start a conversion on the small instance and wait for done (bounded).
    // lat counts negedges after the cycle following the accepting edge.
    task automatic run_s(input logic [6:0] v, output logic got, output int lat,
                         output int busy_n, output logic [7:0] bcd, output logic ovf);
        got = 1'b0; lat = 0; busy_n = 0; bcd = 'x; ovf = 1'bx;
        @(negedge clk);
        s_if.start_i = 1'b1;
        s_if.bin_i   = v;
        @(negedge clk);
        s_if.start_i = 1'b0;
        if (s_if.busy_o) busy_n++;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (s_if.busy_o) busy_n++;
            if (s_if.done_o) begin
                got = 1'b1; lat = k; bcd = s_if.bcd_o; ovf = s_if.ovf_o;
                break;
            end
        end
        $display("small conv bin=%0d bcd=%h ovf=%b lat=%0d busy=%0d", v, bcd, ovf, lat, busy_n);
    endtask

    // Same as run_s for the default instance.
    task automatic run_d(input logic [15:0] v, output logic got, output int lat,
                         output int busy_n, output logic [19:0] bcd, output logic ovf);
        got = 1'b0; lat = 0; busy_n = 0; bcd = 'x; ovf = 1'bx;
        @(negedge clk);
        d_if.start_i = 1'b1;
        d_if.bin_i   = v;
        @(negedge clk);
        d_if.start_i = 1'b0;
        if (d_if.busy_o) busy_n++;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (d_if.busy_o) busy_n++;
            if (d_if.done_o) begin
                got = 1'b1; lat = k; bcd = d_if.bcd_o; ovf = d_if.ovf_o;
                break;
            end
        end
        $display("dflt conv bin=%0d bcd=%h ovf=%b lat=%0d busy=%0d", v, bcd, ovf, lat, busy_n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_if.start_i = 1'b0; s_if.bin_i = '0;
        d_if.start_i = 1'b0; d_if.bin_i = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({d_if.busy_o, d_if.done_o, d_if.ovf_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/done/ovf=%b required 000", {d_if.busy_o, d_if.done_o, d_if.ovf_o});
        end
        n_checks++;
        if (d_if.bcd_o !== 20'h00000) begin
            n_fail++;
            $display("FAIL reset_bcd: got %h required 00000", d_if.bcd_o);
        end
        n_checks++;
        if ({s_if.busy_o, s_if.done_o, s_if.ovf_o, s_if.bcd_o} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_small: got %b required all zero", {s_if.busy_o, s_if.done_o, s_if.ovf_o, s_if.bcd_o});
        end
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_small_99();
        logic got; int lat; int busy_n; logic [7:0] bcd; logic ovf;
        run_s(7'd99, got, lat, busy_n, bcd, ovf);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL small99_done: got no done within bound, required done");
        end
        n_checks++;
        if (lat !== 7 || busy_n !== 7) begin
            n_fail++;
            $display("FAIL small99_timing: got lat=%0d busy=%0d required lat=7 busy=7", lat, busy_n);
        end
        n_checks++;
        if (bcd !== 8'h99 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL small99_result: got %h ovf=%b required 99 ovf=0", bcd, ovf);
        end
        @(negedge clk);
        n_checks++;
        if (s_if.done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL small99_pulse: got done=%b one cycle later required 0", s_if.done_o);
        end
    endtask

    task automatic test_small_overflow();
        logic got; int lat; int busy_n; logic [7:0] bcd; logic ovf;
        run_s(7'd127, got, lat, busy_n, bcd, ovf);
        n_checks++;
        if (!got || bcd !== 8'h27 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL small127: got done=%b %h ovf=%b required 27 ovf=1", got, bcd, ovf);
        end
        run_s(7'd0, got, lat, busy_n, bcd, ovf);
        n_checks++;
        if (!got || lat !== 7 || bcd !== 8'h00 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL small0: got done=%b lat=%0d %h ovf=%b required lat=7 00 ovf=0", got, lat, bcd, ovf);
        end
    endtask

    task automatic test_max();
        logic got; int lat; int busy_n; logic [19:0] bcd; logic ovf;
        run_d(16'd65535, got, lat, busy_n, bcd, ovf);
        n_checks++;
        if (!got || lat !== 16 || busy_n !== 16) begin
            n_fail++;
            $display("FAIL max_timing: got done=%b lat=%0d busy=%0d required lat=16 busy=16", got, lat, busy_n);
        end
        n_checks++;
        if (bcd !== 20'h65535 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL max_result: got %h ovf=%b required 65535 ovf=0", bcd, ovf);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (d_if.bcd_o !== 20'h65535 || d_if.done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL max_hold: got %h done=%b required 65535 done=0", d_if.bcd_o, d_if.done_o);
        end
        run_d(16'd1, got, lat, busy_n, bcd, ovf);
        n_checks++;
        if (!got || bcd !== 20'h00001 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL one: got done=%b %h ovf=%b required 00001 ovf=0", got, bcd, ovf);
        end
        run_d(16'd9050, got, lat, busy_n, bcd, ovf);
        n_checks++;
        if (!got || bcd !== 20'h09050 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL p9050: got done=%b %h ovf=%b required 09050 ovf=0", got, bcd, ovf);
        end
    endtask

    task automatic test_busy_ignore();
        int ndone; int first_k; logic [19:0] bcd;
        ndone = 0; first_k = 0; bcd = 'x;
        @(negedge clk);
        d_if.start_i = 1'b1;
        d_if.bin_i   = 16'd1234;
        @(negedge clk);
        d_if.start_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (d_if.done_o) begin
                ndone++;
                if (ndone == 1) begin first_k = k; bcd = d_if.bcd_o; end
            end
            if (k == 5) begin d_if.start_i = 1'b1; d_if.bin_i = 16'd9999; end
            if (k == 6) d_if.start_i = 1'b0;
        end
        $display("busy-ignore conv bin=1234 bcd=%h dones=%0d lat=%0d", bcd, ndone, first_k);
        n_checks++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL busy_ignore_count: got %0d done pulses required 1", ndone);
        end
        n_checks++;
        if (bcd !== 20'h01234 || first_k !== 16) begin
            n_fail++;
            $display("FAIL busy_ignore_result: got %h lat=%0d required 01234 lat=16", bcd, first_k);
        end
    endtask

    task automatic test_reset_mid();
        int ndone; logic got; int lat; int busy_n; logic [19:0] bcd; logic ovf;
        ndone = 0;
        @(negedge clk);
        d_if.start_i = 1'b1;
        d_if.bin_i   = 16'd4321;
        @(negedge clk);
        d_if.start_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (d_if.done_o) ndone++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({d_if.busy_o, d_if.done_o, d_if.ovf_o} !== 3'b000 || d_if.bcd_o !== 20'h00000) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b ovf=%b bcd=%h required all zero",
                     d_if.busy_o, d_if.done_o, d_if.ovf_o, d_if.bcd_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (d_if.done_o) ndone++;
        end
        $display("reset-mid conv bin=4321 abandoned dones=%0d", ndone);
        n_checks++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_nodone: got %0d done pulses required 0", ndone);
        end
        run_d(16'd42, got, lat, busy_n, bcd, ovf);
        n_checks++;
        if (!got || bcd !== 20'h00042 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got done=%b %h ovf=%b required 00042 ovf=0", got, bcd, ovf);
        end
    endtask

    // start_i held high through the first done cycle: the second operand is
    // accepted on the done cycle, so done pulses are BIN_W+1 negedges apart
    // (BIN_W busy cycles plus the done/accept cycle).
    task automatic test_back_to_back();
        int ndone; int k1; int k2; logic [19:0] bcd1; logic [19:0] bcd2;
        ndone = 0; k1 = 0; k2 = 0; bcd1 = 'x; bcd2 = 'x;
        @(negedge clk);
        d_if.start_i = 1'b1;
        d_if.bin_i   = 16'd10;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (ndone == 1 && k == k1 + 1) d_if.start_i = 1'b0;
            if (d_if.done_o) begin
                ndone++;
                if (ndone == 1) begin k1 = k; bcd1 = d_if.bcd_o; d_if.bin_i = 16'd20; end
                if (ndone == 2) begin k2 = k; bcd2 = d_if.bcd_o; end
            end
        end
        d_if.start_i = 1'b0;
        $display("b2b conv bin=10 bcd=%h at %0d, bin=20 bcd=%h at %0d, dones=%0d", bcd1, k1, bcd2, k2, ndone);
        n_checks++;
        if (ndone !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d done pulses required 2", ndone);
        end
        n_checks++;
        if (bcd1 !== 20'h00010 || bcd2 !== 20'h00020) begin
            n_fail++;
            $display("FAIL b2b_result: got %h,%h required 00010,00020", bcd1, bcd2);
        end
        n_checks++;
        if (k1 !== 17 || (k2 - k1) !== 17) begin
            n_fail++;
            $display("FAIL b2b_spacing: got first=%0d gap=%0d required first=17 gap=17", k1, k2 - k1);
        end
    endtask

    initial begin
        test_reset();
        test_small_99();
        test_small_overflow();
        test_max();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
